time_counter: RTL and testbench

Time-of-day counter for the MyClock design, directly downstream of the 100 ms divider. It consumes the divider's `clk_ls` square wave, counts one tenth-of-second per `clk_ls` rising edge, and keeps packed-BCD tenths, seconds, minutes and hours (24 h). It also accepts minute/hour adjust buttons and a run/pause control. Its outputs feed the display multiplexer.

---
 rtl/time_counter.sv | 128 ++++++++++++
 tb/tb_time_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// time_counter: BCD time-of-day counter (tenths/sec/min/hr) driven by 100 ms clk_ls edges.
// Latency: counters and sec_pulse update one clk edge after clk_ls rises; adjust one edge after a button rises.
// Backpressure: none; a tick arriving while paused or alongside an adjust edge is discarded.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   clk_ls              100 ms square wave, already in the clk domain
//   run                 1 = count, 0 = pause
//   inc_min, inc_hr     debounced button levels; each rising edge adds one
//   tenth               binary 0-9
//   sec, min, hr        packed BCD {tens,units}
//   sec_pulse           one-clk pulse whenever counting advances sec
// Optional feature macro TIME_COUNTER_ALARM_EN adds alarm_hr, alarm_min (BCD inputs)
// and the registered alarm flag.
module time_counter #(
  parameter logic [7:0] HOUR_MAX = 8'h23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_ls,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hr,
`ifdef TIME_COUNTER_ALARM_EN
  input  logic [7:0] alarm_hr,
  input  logic [7:0] alarm_min,
  output logic       alarm,
`endif
  output logic [3:0] tenth,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hr,
  output logic       sec_pulse
);

  // Packed-BCD increment with wrap to 00 at 'top'; units roll into tens so
  // neither nibble ever holds A-F.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic ls_d, inc_min_d, inc_hr_d;
  logic tick, adj_min, adj_hr;

  // Delay registers reset high so an input already high out of reset gives no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_d      <= 1'b1;
      inc_min_d <= 1'b1;
      inc_hr_d  <= 1'b1;
    end else begin
      ls_d      <= clk_ls;
      inc_min_d <= inc_min;
      inc_hr_d  <= inc_hr;
    end
  end

  assign tick    = clk_ls  & ~ls_d;
  assign adj_min = inc_min & ~inc_min_d;
  assign adj_hr  = inc_hr  & ~inc_hr_d;

  logic [3:0] tenth_n;
  logic [7:0] sec_n, min_n, hr_n;
  logic       pulse_n;

  always_comb begin
    tenth_n = tenth;
    sec_n   = sec;
    min_n   = min;
    hr_n    = hr;
    pulse_n = 1'b0;
    if (adj_min || adj_hr) begin
      // Adjust wins over a coincident tick; that tick is simply lost.
      if (adj_min) min_n = bcd_inc(min, 8'h59);
      if (adj_hr)  hr_n  = bcd_inc(hr, HOUR_MAX);
    end else if (tick && run) begin
      if (tenth == 4'd9) begin
        tenth_n = 4'd0;
        pulse_n = 1'b1;
        sec_n   = bcd_inc(sec, 8'h59);
        if (sec == 8'h59) begin
          min_n = bcd_inc(min, 8'h59);
          if (min == 8'h59)
            hr_n = bcd_inc(hr, HOUR_MAX);
        end
      end else begin
        tenth_n = tenth + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tenth     <= 4'd0;
      sec       <= 8'h00;
      min       <= 8'h00;
      hr        <= 8'h00;
      sec_pulse <= 1'b0;
    end else begin
      tenth     <= tenth_n;
      sec       <= sec_n;
      min       <= min_n;
      hr        <= hr_n;
      sec_pulse <= pulse_n;
    end
  end

`ifdef TIME_COUNTER_ALARM_EN
  logic alarm_hit;
  assign alarm_hit = run && (hr == alarm_hr) && (min == alarm_min) &&
                     (sec == 8'h00) && (tenth == 4'd0);

  // Latches on the exact alarm instant and holds for the rest of that minute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      alarm <= 1'b0;
    else if (alarm_hit)
      alarm <= 1'b1;
    else if (min != alarm_min)
      alarm <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_time_counter.sv
module tb_time_counter;
  localparam int HOURS = 24;
  localparam int DAY   = HOURS * 36000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_ls = 1'b1;
  logic       run = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hr = 1'b0;
  logic [3:0] tenth;
  logic [7:0] sec, min, hr;
  logic       sec_pulse;
`ifdef TIME_COUNTER_ALARM_EN
  logic [7:0] alarm_hr = 8'h07;
  logic [7:0] alarm_min = 8'h30;
  logic       alarm;
`endif

  time_counter dut (
    .clk(clk), .rst_n(rst_n), .clk_ls(clk_ls), .run(run),
    .inc_min(inc_min), .inc_hr(inc_hr),
`ifdef TIME_COUNTER_ALARM_EN
    .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm(alarm),
`endif
    .tenth(tenth), .sec(sec), .min(min), .hr(hr), .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: total tenths since midnight, plus previous input levels.
  int   t = 0;
  logic m_ls = 1'b1, m_im = 1'b1, m_ih = 1'b1;
  logic exp_pulse = 1'b0;
  logic exp_alarm = 1'b0;
  int   pulse_seen = 0;
  int   bad_bcd = 0;

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_model();
    check("tenth", {4'h0, tenth}, 8'(t % 10));
    check("sec", sec, to_bcd((t / 10) % 60));
    check("min", min, to_bcd((t / 600) % 60));
    check("hr", hr, to_bcd(t / 36000));
    check("sec_pulse", {7'h0, sec_pulse}, {7'h0, exp_pulse});
`ifdef TIME_COUNTER_ALARM_EN
    check("alarm", {7'h0, alarm}, {7'h0, exp_alarm});
`endif
  endtask

  // One clock: drive at negedge, advance the model, compare after the posedge.
  task automatic cycle(input logic ls, input logic r, input logic im, input logic ih);
    logic tk, am, ah;
    int m0, h0;
    @(negedge clk);
    clk_ls = ls; run = r; inc_min = im; inc_hr = ih;
    tk = ls & ~m_ls;
    am = im & ~m_im;
    ah = ih & ~m_ih;
    m_ls = ls; m_im = im; m_ih = ih;
`ifdef TIME_COUNTER_ALARM_EN
    if (r && t == 7 * 36000 + 30 * 600)
      exp_alarm = 1'b1;
    else if ((t / 600) % 60 != 30)
      exp_alarm = 1'b0;
`endif
    exp_pulse = 1'b0;
    if (am || ah) begin
      if (am) begin
        m0 = (t / 600) % 60;
        t = t + (((m0 + 1) % 60) - m0) * 600;
      end
      if (ah) begin
        h0 = t / 36000;
        t = t + (((h0 + 1) % HOURS) - h0) * 36000;
      end
    end else if (tk && r) begin
      exp_pulse = (t % 10 == 9);
      t = (t + 1) % DAY;
    end
    @(posedge clk);
    #1;
    if (sec_pulse === 1'b1) pulse_seen++;
    if (sec[3:0] > 4'd9) bad_bcd++;
    check_model();
  endtask

  task automatic ticks(input int n, input int p, input logic r);
    for (int k = 0; k < n; k++) begin
      repeat (p / 2) cycle(1'b0, r, 1'b0, 1'b0);
      repeat (p / 2) cycle(1'b1, r, 1'b0, 1'b0);
    end
  endtask

  task automatic press_min(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(m_ls, 1'b1, 1'b1, 1'b0);
      cycle(m_ls, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic press_hr(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(m_ls, 1'b1, 1'b0, 1'b1);
      cycle(m_ls, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_tenth", {4'h0, tenth}, 8'h00);
    check("rst_sec", sec, 8'h00);
    check("rst_min", min, 8'h00);
    check("rst_hr", hr, 8'h00);
    check("rst_pulse", {7'h0, sec_pulse}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0; m_ls = 1'b1; m_im = 1'b1; m_ih = 1'b1;
    exp_pulse = 1'b0; exp_alarm = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int p0;
    logic [3:0] tn0;
    logic nls, nr, nim, nih;

    // Reset with clk_ls held high: release must not produce a tick.
    repeat (3) @(negedge clk);
    check("init_tenth", {4'h0, tenth}, 8'h00);
    check("init_sec", sec, 8'h00);
    rst_n = 1'b1;
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // Ten 20-cycle periods make exactly one second and one pulse.
    pulse_seen = 0;
    ticks(10, 20, 1'b1);
    check("ten_periods_sec", sec, 8'h01);
    check("ten_periods_tenth", {4'h0, tenth}, 8'h00);
    check("ten_periods_pulses", 8'(pulse_seen), 8'd1);

    // Pause across five edges, then resume.
    p0 = pulse_seen;
    tn0 = tenth;
    ticks(5, 20, 1'b0);
    check("pause_tenth", {4'h0, tenth}, {4'h0, tn0});
    check("pause_pulses", 8'(pulse_seen), 8'(p0));
    ticks(1, 20, 1'b1);
    check("resume_tenth", {4'h0, tenth}, {4'h0, tn0 + 4'd1});

    // Mid-operation asynchronous reset.
    ticks(3, 6, 1'b1);
    do_reset();

    // Preload to 23:59:59.9 then roll the whole day over.
    press_hr(23);
    press_min(59);
    ticks(599, 4, 1'b1);
    check("pre_hr", hr, 8'h23);
    check("pre_sec", sec, 8'h59);
    ticks(1, 4, 1'b1);
    check("wrap_hr", hr, 8'h00);
    check("wrap_min", min, 8'h00);
    check("wrap_sec", sec, 8'h00);
    check("wrap_tenth", {4'h0, tenth}, 8'h00);
    check("bcd_digits", 8'(bad_bcd), 8'd0);

    // Held minute button at 05:59: single increment, no carry into hours.
    do_reset();
    press_hr(5);
    press_min(59);
    repeat (100) cycle(m_ls, 1'b1, 1'b1, 1'b0);
    cycle(m_ls, 1'b1, 1'b0, 1'b0);
    check("hold_min", min, 8'h00);
    check("hold_hr", hr, 8'h05);

    // Hour button rising in the same cycle as a tick: tick dropped.
    ticks(2, 4, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    tn0 = tenth;
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("coinc_hr", hr, 8'h06);
    check("coinc_tenth", {4'h0, tenth}, {4'h0, tn0});
    cycle(1'b1, 1'b1, 1'b0, 1'b0);

`ifdef TIME_COUNTER_ALARM_EN
    do_reset();
    press_hr(7);
    press_min(29);
    ticks(600, 4, 1'b1);
    cycle(m_ls, 1'b1, 1'b0, 1'b0);
    check("alarm_set", {7'h0, alarm}, 8'h01);
    press_min(1);
    cycle(m_ls, 1'b1, 1'b0, 1'b0);
    check("alarm_clear", {7'h0, alarm}, 8'h00);
`endif

    // Randomized clk_ls, run and button activity against the model.
    for (int i = 0; i < 5000; i++) begin
      nls = ($urandom_range(0, 2) == 0) ? ~m_ls : m_ls;
      nr  = ($urandom_range(0, 7) != 0);
      nim = ($urandom_range(0, 40) == 0) ? ~m_im : m_im;
      nih = ($urandom_range(0, 60) == 0) ? ~m_ih : m_ih;
      cycle(nls, nr, nim, nih);
    end
    check("rand_bcd_digits", 8'(bad_bcd), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
